// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - register offsets decoded from Addr[3:2]
//   - STATUS and CTRL bit positions
//   - the transmit state encoding
//   - eff_div(): maps a programmed divisor to the one actually used
// -----------------------------------------------------------------------------
package uart_pkg;

  // Word offsets within the device window (Addr[3:2])
  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_DIVISOR = 2'd3;

  // STATUS fields; the FIFO count occupies bits [STAT_COUNT_LSB +: 4]
  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 4;

  // CTRL fields
  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // A divisor of zero would never complete a bit, so it behaves as one.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Small synchronous FIFO holding bytes waiting to be serialised.
//   clk, reset : system clock, synchronous active-high reset (empties FIFO)
//   push, din  : write din at the clock edge when there is room
//   pop        : drop the head entry at the clock edge (ignored when empty)
//   head       : current head entry (valid when !empty)
//   count      : number of stored entries
//   full/empty : occupancy flags
// A push to a full FIFO is still accepted when a pop happens on the same edge.
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a simultaneous pop frees the slot this push needs
  assign do_push = push & (~full | do_pop);

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  // Next storage, pointer and occupancy values from the accepted push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers and count are reset; the storage itself need not be.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_dev.sv
// -----------------------------------------------------------------------------
// uart_tx_dev
// Memory-mapped 8N1 UART transmitter (LSB first) for the South Bridge port.
//   clk, reset : system clock, synchronous active-high reset
//   Addr[31:2] : word address, only Addr[3:2] decoded
//   WE, Din    : register write, committed at the clock edge
//   Dout       : combinational read data for Addr[3:2]
//   IRQ        : registered level interrupt (irq_en & FIFO empty & idle)
//   tx         : registered serial line, idles high
// Registers: 0 DATA (push), 1 STATUS, 2 CTRL {irq_en, tx_en}, 3 DIVISOR.
// -----------------------------------------------------------------------------
module uart_tx_dev
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_RESET  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] div_lat_q, div_lat_d;
  logic [15:0] divisor_q, divisor_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        tx_en_q, tx_en_d;
  logic        irq_en_q, irq_en_d;
  logic        ovf_q, ovf_d;
  logic        irq_q, irq_d;

  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic          wr_data, wr_status, wr_ctrl, wr_div;
  logic          baud_done, load_frame;
  logic          unused_bits;

  assign wr_data   = WE && (Addr[3:2] == REG_DATA);
  assign wr_status = WE && (Addr[3:2] == REG_STATUS);
  assign wr_ctrl   = WE && (Addr[3:2] == REG_CTRL);
  assign wr_div    = WE && (Addr[3:2] == REG_DIVISOR);

  // upper address bits are decoded by the South Bridge
  assign unused_bits = ^{Addr[31:4], Din[31:16]};

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data),
    .pop   (fifo_pop),
    .din   (Din[7:0]),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // last cycle of the current bit period
  assign baud_done = (baud_q == div_lat_q - 16'd1);
  assign fifo_pop  = load_frame;

  // All state flops; reset aborts any frame and returns the line high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= TX_IDLE;
      baud_q    <= '0;
      div_lat_q <= eff_div(16'(DIV_RESET));
      divisor_q <= 16'(DIV_RESET);
      bit_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      tx_en_q   <= 1'b0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      div_lat_q <= div_lat_d;
      divisor_q <= divisor_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      tx_en_q   <= tx_en_d;
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
    end
  end

  // Next-state logic. A new frame is loaded from IDLE or straight out of
  // STOP so queued bytes go out back to back with no idle gap.
  always_comb begin
    state_d    = state_q;
    load_frame = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (tx_en_q && !fifo_empty) begin
          load_frame = 1'b1;
          state_d    = TX_START;
        end
      end
      TX_START: begin
        if (baud_done) state_d = TX_DATA;
      end
      TX_DATA: begin
        if (baud_done && (bit_q == 3'd7)) state_d = TX_STOP;
      end
      TX_STOP: begin
        if (baud_done) begin
          if (tx_en_q && !fifo_empty) begin
            load_frame = 1'b1;
            state_d    = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Datapath for the line: the divisor is latched per frame so DIVISOR
  // writes mid-frame only affect the next frame.
  always_comb begin
    tx_d      = tx_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    div_lat_d = div_lat_q;
    baud_d    = baud_done ? 16'd0 : baud_q + 16'd1;
    if (load_frame) begin
      shift_d   = fifo_head;
      div_lat_d = eff_div(divisor_q);
      baud_d    = '0;
      tx_d      = 1'b0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          baud_d = '0;
          tx_d   = 1'b1;
        end
        TX_START: begin
          if (baud_done) begin
            tx_d  = shift_q[0];
            bit_d = '0;
          end
        end
        TX_DATA: begin
          if (baud_done) begin
            if (bit_q == 3'd7) begin
              tx_d = 1'b1;
            end else begin
              shift_d = {1'b0, shift_q[7:1]};
              bit_d   = bit_q + 3'd1;
              tx_d    = shift_q[1];
            end
          end
        end
        TX_STOP: begin
          if (baud_done) tx_d = 1'b1;
        end
        default: tx_d = 1'b1;
      endcase
    end
  end

  // Register writes, sticky overflow and the registered interrupt.
  always_comb begin
    tx_en_d   = tx_en_q;
    irq_en_d  = irq_en_q;
    divisor_d = divisor_q;
    ovf_d     = ovf_q;
    if (wr_ctrl) begin
      tx_en_d  = Din[CTRL_TX_EN];
      irq_en_d = Din[CTRL_IRQ_EN];
    end
    if (wr_div) divisor_d = Din[15:0];
    if (wr_status) begin
      ovf_d = 1'b0;
    end else if (wr_data && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end
    irq_d = irq_en_q & fifo_empty & (state_q == TX_IDLE);
  end

  // Read mux; unused bits read as zero.
  always_comb begin
    Dout = '0;
    case (Addr[3:2])
      REG_STATUS: begin
        Dout[STAT_BUSY]             = (state_q != TX_IDLE);
        Dout[STAT_FULL]             = fifo_full;
        Dout[STAT_EMPTY]            = fifo_empty;
        Dout[STAT_OVERFLOW]         = ovf_q;
        Dout[STAT_COUNT_LSB +: 4]   = 4'(fifo_count);
      end
      REG_CTRL:    Dout[1:0]  = {irq_en_q, tx_en_q};
      REG_DIVISOR: Dout[15:0] = divisor_q;
      default:     Dout       = '0;
    endcase
  end

  assign tx  = tx_q;
  assign IRQ = irq_q;

endmodule

// File: tb/tb_uart_tx_dev.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_dev
// Directed bench for uart_tx_dev: register reset values, single and
// back-to-back frames, FIFO overflow, interrupt behaviour, disabling the
// transmitter mid-frame and reset mid-frame. Expected line levels come from
// a small frame model (start bit, 8 data bits LSB first, stop bit).
// -----------------------------------------------------------------------------
module tb_uart_tx_dev;
  import uart_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  logic        tx;

  int testsRun;
  int testsFailed;

  logic [7:0]  frameBytes [4];
  logic [31:0] rdData;

  uart_tx_dev #(
    .FIFO_DEPTH (4),
    .DIV_RESET  (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ),
    .tx    (tx)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Register write committed at the next posedge; returns 1 time unit later
  task automatic applyStimulus(input logic [1:0] regIdx, input logic [31:0] data);
    @(negedge clk);
    Addr = {28'd0, regIdx};
    Din  = data;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE   = 1'b0;
    Din  = '0;
  endtask

  // Combinational register read sampled at the falling edge
  task automatic readReg(input logic [1:0] regIdx, output logic [31:0] data);
    @(negedge clk);
    Addr = {28'd0, regIdx};
    WE   = 1'b0;
    #1;
    data = Dout;
  endtask

  // Expected line level at bit position pos (0 start .. 9 stop) of a frame
  function automatic logic frameBit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  // Expected STATUS while busy with count entries still queued
  function automatic logic [31:0] busyStatus(input int cnt);
    logic [31:0] s;
    s = 32'h1;
    if (cnt == 0) s[STAT_EMPTY] = 1'b1;
    s[7:4] = 4'(cnt);
    return s;
  endfunction

  // Follows nFrames contiguous frames from frameBytes starting at the edge
  // after a triggering write, checking line, STATUS and optionally IRQ=0,
  // then one more cycle expecting an idle line.
  task automatic watchLine(input int div, input int nFrames, input bit irqLow,
                           input string name);
    int total;
    int idx;
    int pos;
    total = 10 * div * nFrames;
    Addr  = {28'd0, REG_STATUS};
    for (int k = 1; k <= total; k++) begin
      @(posedge clk);
      #1;
      idx = (k - 1) / (10 * div);
      pos = ((k - 1) / div) % 10;
      checkOutput($sformatf("%s tx k=%0d", name, k), {31'd0, tx},
                  {31'd0, frameBit(frameBytes[idx], pos)});
      checkOutput($sformatf("%s status k=%0d", name, k), Dout,
                  busyStatus(nFrames - idx - 1));
      if (irqLow) checkOutput($sformatf("%s irq k=%0d", name, k), {31'd0, IRQ}, 32'd0);
    end
    @(posedge clk);
    #1;
    checkOutput($sformatf("%s idle tx", name), {31'd0, tx}, 32'd1);
    checkOutput($sformatf("%s idle status", name), Dout, 32'h4);
    if (irqLow) checkOutput($sformatf("%s idle irq", name), {31'd0, IRQ}, 32'd0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset = 1'b1;
    Addr  = '0;
    WE    = 1'b0;
    Din   = '0;
    for (int i = 0; i < 4; i++) frameBytes[i] = 8'h00;

    // ---------------- reset values ----------------
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset tx", {31'd0, tx}, 32'd1);
    checkOutput("reset irq", {31'd0, IRQ}, 32'd0);
    readReg(REG_DATA, rdData);    checkOutput("reset DATA", rdData, 32'h0);
    readReg(REG_STATUS, rdData);  checkOutput("reset STATUS", rdData, 32'h4);
    readReg(REG_CTRL, rdData);    checkOutput("reset CTRL", rdData, 32'h0);
    readReg(REG_DIVISOR, rdData); checkOutput("reset DIVISOR", rdData, 32'd16);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset tx later", {31'd0, tx}, 32'd1);
    checkOutput("reset irq later", {31'd0, IRQ}, 32'd0);

    // ---------------- single frame, div 4 ----------------
    applyStimulus(REG_DIVISOR, 32'hABCD_0004);
    readReg(REG_DIVISOR, rdData); checkOutput("divisor upper bits", rdData, 32'h4);
    applyStimulus(REG_CTRL, 32'h1);
    readReg(REG_CTRL, rdData);    checkOutput("ctrl readback", rdData, 32'h1);
    frameBytes[0] = 8'hA5;
    applyStimulus(REG_DATA, 32'h0000_00A5);
    watchLine(4, 1, 1'b0, "single");

    // ---------------- back-to-back, div 1 ----------------
    applyStimulus(REG_CTRL, 32'h0);
    applyStimulus(REG_DIVISOR, 32'h1);
    applyStimulus(REG_DATA, 32'h00);
    applyStimulus(REG_DATA, 32'hFF);
    readReg(REG_STATUS, rdData);  checkOutput("b2b queued", rdData, 32'h20);
    frameBytes[0] = 8'h00;
    frameBytes[1] = 8'hFF;
    applyStimulus(REG_CTRL, 32'h1);
    watchLine(1, 2, 1'b0, "b2b");

    // ---------------- overflow, divisor 0 acts as 1 ----------------
    applyStimulus(REG_CTRL, 32'h0);
    applyStimulus(REG_DIVISOR, 32'h0);
    applyStimulus(REG_DATA, 32'h11);
    applyStimulus(REG_DATA, 32'h22);
    applyStimulus(REG_DATA, 32'h33);
    applyStimulus(REG_DATA, 32'h44);
    readReg(REG_STATUS, rdData);  checkOutput("ovf full no flag", rdData, 32'h42);
    applyStimulus(REG_DATA, 32'h55);
    readReg(REG_STATUS, rdData);  checkOutput("ovf flagged", rdData, 32'h4A);
    applyStimulus(REG_STATUS, 32'h0);
    readReg(REG_STATUS, rdData);  checkOutput("ovf cleared", rdData, 32'h42);
    readReg(REG_DIVISOR, rdData); checkOutput("divisor zero", rdData, 32'h0);
    frameBytes[0] = 8'h11;
    frameBytes[1] = 8'h22;
    frameBytes[2] = 8'h33;
    frameBytes[3] = 8'h44;
    applyStimulus(REG_CTRL, 32'h1);
    watchLine(1, 4, 1'b0, "ovf drain");

    // ---------------- interrupt ----------------
    applyStimulus(REG_DIVISOR, 32'h2);
    applyStimulus(REG_CTRL, 32'h3);
    checkOutput("irq before update", {31'd0, IRQ}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("irq idle empty", {31'd0, IRQ}, 32'd1);
    frameBytes[0] = 8'h5A;
    applyStimulus(REG_DATA, 32'h5A);
    watchLine(2, 1, 1'b1, "irq");
    @(posedge clk);
    #1;
    checkOutput("irq rises", {31'd0, IRQ}, 32'd1);
    applyStimulus(REG_CTRL, 32'h1);
    checkOutput("irq holds one cycle", {31'd0, IRQ}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("irq cleared", {31'd0, IRQ}, 32'd0);

    // ---------------- disable mid-frame ----------------
    applyStimulus(REG_CTRL, 32'h0);
    applyStimulus(REG_DATA, 32'h3C);
    applyStimulus(REG_DATA, 32'hC3);
    applyStimulus(REG_CTRL, 32'h1);
    Addr = {28'd0, REG_STATUS};
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("disable tx k=%0d", k), {31'd0, tx},
                  {31'd0, frameBit(8'h3C, (k - 1) / 2)});
      if (k != 7) checkOutput($sformatf("disable status k=%0d", k), Dout, 32'h11);
      if (k == 6) begin
        Addr = {28'd0, REG_CTRL};
        Din  = 32'h0;
        WE   = 1'b1;
      end
      if (k == 7) begin
        WE   = 1'b0;
        Addr = {28'd0, REG_STATUS};
      end
    end
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("held tx k=%0d", k), {31'd0, tx}, 32'd1);
      checkOutput($sformatf("held status k=%0d", k), Dout, 32'h10);
    end

    // ---------------- reset mid-frame ----------------
    applyStimulus(REG_CTRL, 32'h1);
    Addr = {28'd0, REG_STATUS};
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("prereset tx k=%0d", k), {31'd0, tx},
                  {31'd0, frameBit(8'hC3, (k - 1) / 2)});
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("midreset tx", {31'd0, tx}, 32'd1);
    checkOutput("midreset status", Dout, 32'h4);
    checkOutput("midreset irq", {31'd0, IRQ}, 32'd0);
    readReg(REG_DIVISOR, rdData); checkOutput("midreset DIVISOR", rdData, 32'd16);
    readReg(REG_CTRL, rdData);    checkOutput("midreset CTRL", rdData, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("postreset tx", {31'd0, tx}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_tx_dev.md
Name: uart_tx_dev

Overview:
- Memory-mapped UART transmitter that sits as a device on the South Bridge device port, alongside the timers.
- The CPU writes bytes into a small TX FIFO. The block serialises them as 8N1 frames, LSB first, on a single output line.
- It raises a level interrupt when the FIFO has drained and the line is idle.
- Its bus side uses the same word-addressed Addr/WE/Din/Dout/IRQ shape as the Timer devices.

Parameters:
- FIFO_DEPTH, 4, TX FIFO entries; must be a power of two, at least 2.
- DIV_RESET, 16, reset value of the DIVISOR register (clock cycles per bit).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- Addr  input  [31:2]  word address; only Addr[3:2] is decoded.
- WE  input  1  write enable; the write commits at the posedge of clk.
- Din  input  32  write data.
- Dout  output  32  read data; combinational from Addr[3:2] and current register state.
- IRQ  output  1  interrupt request, level.
- tx  output  1  serial line, registered, idles high.

Behaviour:
- Register map (Addr[3:2]):
  - 0 DATA. A write pushes Din[7:0]. A read returns 0.
  - 1 STATUS. Read-only except for overflow clear. Fields:
    - bit0 busy (state != IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - bits[7:4] FIFO count
    - all other bits 0
    - Any write to STATUS clears overflow.
  - 2 CTRL. bit0 tx_en, bit1 irq_en. A read returns {30'b0, irq_en, tx_en}.
  - 3 DIVISOR. bits[15:0] R/W; upper bits read 0. A value of 0 is treated as 1.
- Reset values:
  - tx=1, state=IDLE, FIFO empty, overflow=0, CTRL=0, DIVISOR=DIV_RESET, IRQ=0.
  - Reset mid-frame aborts the frame and drives tx=1 on the next cycle.
- FIFO push:
  - A DATA write when not full is accepted; count increments after the edge.
  - A DATA write when full is dropped and sets overflow.
  - If a pop happens on the same edge as a push to a full FIFO, the push is accepted and count is unchanged.
- TX state machine: IDLE, START, DATA, STOP.
  - A baud counter counts 0..div-1. A bit counter covers 0..7.
  - IDLE: when tx_en=1 and FIFO is non-empty at a posedge:
    - pop the head into the shift register
    - latch the divisor (0 becomes 1)
    - tx<=0, state<=START
  - START: after div cycles, tx<=shift[0], state<=DATA, bit count=0.
  - DATA: every div cycles, shift right and advance the bit. After bit 7's div cycles, tx<=1, state<=STOP.
  - STOP: after div cycles:
    - if tx_en and FIFO non-empty, pop and go directly to START with tx<=0 (no idle gap);
    - otherwise go to IDLE.
  - Frame length is exactly 10*div cycles.
  - Clearing tx_en mid-frame lets the current frame finish; no new frame starts.
  - Writing DIVISOR mid-frame takes effect from the next frame only.
- Latency: a DATA write committed at edge E0 with the block idle and enabled produces tx low from edge E1 onward.
- IRQ:
  - IRQ = irq_en & empty & (state==IDLE), registered, so it updates one cycle after its inputs change.
  - Level-sensitive; it is cleared by pushing data or by clearing irq_en.
- Undecoded upper Addr bits are ignored; the South Bridge performs address decode.

Decomposition:
- Shared package uart_pkg holds:
  - register offsets (DATA=0, STATUS=1, CTRL=2, DIVISOR=3)
  - STATUS bit indices
  - CTRL bit indices
  - the state encoding enum.
- One sub-module, uart_tx_fifo: synchronous FIFO parameterised by width 8 and FIFO_DEPTH.
  - Inputs: push, pop.
  - Outputs: head, count, full, empty.
  - Implements the simultaneous push/pop-when-full rule.
- The FSM, register file and bus decode stay in uart_tx_dev.

Test Plan:
- Reset, then read all four registers:
  - STATUS reads 0x4 (empty);
  - CTRL reads 0; DIVISOR reads 16;
  - tx stays 1 and IRQ stays 0.
- Single frame:
  - Setup: DIVISOR=4, CTRL=1, then write DATA=0xA5.
  - Required: tx is low for 4 cycles from E1, then emits bits 1,0,1,0,0,1,0,1 (4 cycles each), then high for 4 cycles.
  - STATUS.busy=1 throughout those 40 cycles.
- Back-to-back:
  - Setup: DIVISOR=1, push 0x00 and 0xFF.
  - Required: two contiguous 10-cycle frames with no idle gap; empty=1 after the second pop.
- Overflow:
  - Setup: CTRL=0, push 5 bytes.
  - Required: count=4, full=1, overflow=1. A STATUS write clears overflow. Enabling TX sends the first four bytes in order.
- IRQ:
  - Setup: CTRL=3, push one byte with DIVISOR=2.
  - Required: IRQ=0 while sending; IRQ rises one cycle after STOP returns to IDLE. Clearing irq_en drops IRQ next cycle.
- Disable and reset:
  - Clearing tx_en mid-frame completes the frame; a queued byte is held and not sent.
  - Asserting reset mid-frame gives tx=1, count=0, DIVISOR=16 after one edge.
